wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_fifo.sv | 55 +++++
 rtl/wb_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W_DEF = 32;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order queue for long-latency results. Push/pop are ignored when
// full/empty; pointers wrap naturally since DEPTH is a power of two.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointer and occupancy update; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only read behind a valid count.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and queued
// long-latency results onto one registered register-file write port,
// and keeps a busy scoreboard of outstanding long-latency destinations.
// Optional macro WB_BYPASS_EN: an LU result arriving while the queue is
// empty and the ALU is idle is written directly instead of being queued.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        alu_valid,
  input  logic [REG_ADDR_W-1:0]       alu_reg,
  input  logic [DATA_W-1:0]           alu_data,
  input  logic                        lu_valid,
  input  logic [REG_ADDR_W-1:0]       lu_reg,
  input  logic [DATA_W-1:0]           lu_data,
  output logic                        lu_ready,
  input  logic                        issue_valid,
  input  logic [REG_ADDR_W-1:0]       issue_reg,
  output logic                        RegWrite,
  output logic [REG_ADDR_W-1:0]       WriteReg,
  output logic [DATA_W-1:0]           WriteData,
  output logic [31:0]                 busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } req_t;

  logic                  wr_en_q, wr_en_d;
  logic [REG_ADDR_W-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [31:0]           busy_q, busy_d, clr, set;
  logic                  armed_q;  // low until the first edge after reset release
  logic                  alu_el, lu_live, push, pop, byp;
  logic                  fifo_full, fifo_empty;
  req_t                  head, lu_req;

  assign lu_req = '{addr: lu_reg, data: lu_data};

  wb_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (lu_req),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Readiness comes from the registered count only: a dequeue in the same
  // cycle does not free a slot for this cycle's offer.
  assign lu_ready = !fifo_full;

  // Write-port source select (ALU > queue head > bypass > idle) and scoreboard next state.
  always_comb begin
    alu_el    = alu_valid && (alu_reg != '0);
    lu_live   = lu_valid && !fifo_full && (lu_reg != '0);
    wr_en_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    pop       = 1'b0;
    byp       = 1'b0;
    clr       = '0;
    set       = '0;
    if (armed_q) begin
      if (alu_el) begin
        wr_en_d   = 1'b1;
        wr_reg_d  = alu_reg;
        wr_data_d = alu_data;
      end else if (!fifo_empty) begin
        pop            = 1'b1;
        wr_en_d        = 1'b1;
        wr_reg_d       = head.addr;
        wr_data_d      = head.data;
        clr[head.addr] = 1'b1;
      end
`ifdef WB_BYPASS_EN
      else if (lu_live) begin
        byp         = 1'b1;
        wr_en_d     = 1'b1;
        wr_reg_d    = lu_reg;
        wr_data_d   = lu_data;
        clr[lu_reg] = 1'b1;
      end
`endif
    end
    push = lu_live && !byp;
    if (issue_valid && (issue_reg != '0)) set[issue_reg] = 1'b1;
    // A new issue wins over a retiring write to the same register.
    busy_d = (busy_q & ~clr) | set;
  end

  // Registered write port, scoreboard and post-reset arming flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      armed_q   <= 1'b1;
    end
  end

  assign RegWrite  = wr_en_q;
  assign WriteReg  = wr_reg_q;
  assign WriteData = wr_data_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus advances a queue-based
// reference model and pushes expected writes; a monitor pops and compares
// whenever the DUT asserts RegWrite. Build with WB_BYPASS_EN to cover bypass.
module tb_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 0, lu_valid = 0, issue_valid = 0;
  logic [4:0]  alu_reg = 0, lu_reg = 0, issue_reg = 0;
  logic [31:0] alu_data = 0, lu_data = 0;
  logic        lu_ready, RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, busy;
  logic [2:0]  fifo_count;

  wb_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .lu_valid(lu_valid), .lu_reg(lu_reg), .lu_data(lu_data), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;

  // Reference model state (values valid after the coming clock edge).
  wr_t         exp_q[$];
  wr_t         mq[$];
  logic [31:0] mbusy = '0;
  bit          armed = 0;
  bit          m_we = 0;
  logic [4:0]  m_last_r = '0;
  logic [31:0] m_last_d = '0;
  bit          mon_en = 0;
  int          ncmp = 0, nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic step(output bit acc);
    bit ael, byp;
    wr_t w;
    logic [31:0] clr;
    ael = alu_valid && alu_reg != 0;
    acc = lu_valid && (mq.size() < DEPTH);
    byp = 0; clr = '0; m_we = 0; w = '{r: 0, d: 0};
    if (armed) begin
      if (ael) begin
        w = '{r: alu_reg, d: alu_data}; m_we = 1;
      end else if (mq.size() > 0) begin
        w = mq.pop_front(); m_we = 1; clr[w.r] = 1'b1;
      end
`ifdef WB_BYPASS_EN
      else if (acc && lu_reg != 0) begin
        w = '{r: lu_reg, d: lu_data}; m_we = 1; byp = 1; clr[w.r] = 1'b1;
      end
`endif
    end
    if (m_we) begin
      exp_q.push_back(w); m_last_r = w.r; m_last_d = w.d;
    end
    if (acc && lu_reg != 0 && !byp) mq.push_back('{r: lu_reg, d: lu_data});
    mbusy = mbusy & ~clr;
    if (issue_valid && issue_reg != 0) mbusy[issue_reg] = 1'b1;
    armed = 1;
  endtask

  task automatic cyc(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                     input logic iv, input logic [4:0] ir, output bit acc);
    @(negedge clock);
    alu_valid = av; alu_reg = ar; alu_data = ad;
    lu_valid = lv; lu_reg = lr; lu_data = ld;
    issue_valid = iv; issue_reg = ir;
    chk("lu_ready", lu_ready, mq.size() < DEPTH);
    step(acc);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, a);
  endtask

  task automatic do_reset();
    bit a;
    @(negedge clock);
    reset_n = 0;
    alu_valid = 0; lu_valid = 0; issue_valid = 0;
    mq.delete(); exp_q.delete();
    mbusy = '0; armed = 0; m_we = 0; m_last_r = '0; m_last_d = '0;
    #1;
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_writereg", WriteReg, 0);
    chk("rst_writedata", WriteData, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_lu_ready", lu_ready, 1);
    @(negedge clock);
    reset_n = 1;
    step(a);  // first edge after release: nothing may be written
  endtask

  // Monitor: pop an expected write whenever RegWrite is seen.
  initial begin
    wr_t e;
    forever begin
      @(posedge clock); #2;
      if (mon_en) begin
        chk("regwrite", RegWrite, m_we);
        if (RegWrite === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("write_reg", WriteReg, e.r);
            chk("write_data", WriteData, e.d);
          end
        end else begin
          chk("hold_reg", WriteReg, m_last_r);
          chk("hold_data", WriteData, m_last_d);
        end
        chk("busy", busy, mbusy);
        chk("fifo_count", fifo_count, mq.size());
      end
    end
  end

  initial begin
    bit a;
    int li;
    do_reset();
    mon_en = 1;

    // Single ALU write, then idle.
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, a);
    idle(2);

    // Long-latency write to 7 waits behind a 3-cycle ALU stream.
    cyc(0, 0, 0, 0, 0, 0, 1, 7, a);
    cyc(1, 3, 32'hA, 1, 7, 32'h1234, 0, 0, a);
    cyc(1, 4, 32'hB, 0, 0, 0, 0, 0, a);
    cyc(1, 6, 32'hC, 0, 0, 0, 0, 0, a);
    chk("busy7_held", busy[7], 1);
    idle(3);
    chk("busy7_cleared", busy[7], 0);

    // Five LU results against a continuous ALU stream: fill, hold, drain.
    li = 0;
    for (int c = 0; c < 40 && li < 5; c++) begin
      cyc(c < 6, 5'(1 + c % 3), 32'h500 + c, 1, 5'(10 + li), 32'h100 + li, 0, 0, a);
      if (c == 4) begin
        chk("full_count", fifo_count, 4);
        chk("full_not_ready", lu_ready, 0);
      end
      if (a) li++;
    end
    chk("lu_accepts", li, 5);
    idle(8);
    chk("drained", fifo_count, 0);

    // Register 0 on both paths is dropped.
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h77, 1, 0, 32'h88, 0, 0, a);
    chk("r0_count", fifo_count, 0);
    idle(2);

    // Issue to 9 in the same cycle its older write retires: stays busy.
    cyc(1, 2, 32'h22, 1, 9, 32'h99, 0, 0, a);
    cyc(0, 0, 0, 0, 0, 0, 1, 9, a);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, a);
    chk("busy9_set_wins", busy[9], 1);
    idle(2);

    // Reset with three queued entries.
    cyc(0, 0, 0, 0, 0, 0, 1, 4, a);
    cyc(0, 0, 0, 0, 0, 0, 1, 5, a);
    cyc(1, 1, 32'h1, 1, 4, 32'h44, 0, 0, a);
    cyc(1, 1, 32'h2, 1, 5, 32'h55, 0, 0, a);
    cyc(1, 1, 32'h3, 1, 6, 32'h66, 0, 0, a);
    do_reset();
    chk("post_rst_count", fifo_count, 0);
    chk("post_rst_busy", busy, 0);
    cyc(0, 0, 0, 1, 8, 32'h88, 0, 0, a);
    idle(3);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] ar, lr, ir;
      ar = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lr = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ir = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      if ($urandom % 150 == 0) do_reset();
      else cyc(($urandom % 3) == 0, ar, $urandom, ($urandom % 2) == 0, lr, $urandom,
               ($urandom % 3) == 0, ir, a);
    end
    idle(10);
    chk("exp_drained", exp_q.size(), 0);
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
